// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: control codes, funct/alu_op values, FSM states.
package alu_pkg;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_ILL = 3'b100;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU-control decode: alu_op/funct to a 3-bit control code plus an illegal flag.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_ctrl,
    output logic       o_illegal
);

    always_comb begin
        o_ctrl = CTRL_ILL;
        case (i_alu_op)
            ALUOP_ADD: o_ctrl = CTRL_ADD;
            ALUOP_SUB: o_ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FN_AND:  o_ctrl = CTRL_AND;
                    FN_OR:   o_ctrl = CTRL_OR;
                    FN_ADD:  o_ctrl = CTRL_ADD;
                    FN_SUB:  o_ctrl = CTRL_SUB;
                    FN_SLT:  o_ctrl = CTRL_SLT;
                    FN_MULT: o_ctrl = CTRL_MUL;
                    default: o_ctrl = CTRL_ILL;
                endcase
            end
            default: o_ctrl = CTRL_ILL;
        endcase
    end

    assign o_illegal = (o_ctrl == CTRL_ILL);

endmodule

// File: rtl/mc_alu_unit.sv
// Multi-cycle ALU: single-cycle logic/arith ops and a WIDTH-iteration shift-add multiplier
// behind a start/busy/done handshake. Result outputs hold until the next done or reset.
module mc_alu_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [2:0]       aluctrl
);

    logic [2:0]       w_ctrl;
    logic             w_ill;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_psum;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mq_nxt;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
    logic [2:0]       r_aluctrl;

    alu_ctrl_dec u_dec (
        .i_alu_op  (alu_op),
        .i_funct   (funct),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_ill)
    );

    // Subtract shares the adder: a + ~b + 1, and overflow uses the inverted b sign.
    always_comb begin
        w_b_eff = (w_ctrl == CTRL_SUB) ? ~b : b;
        w_sum   = a + w_b_eff + {{(WIDTH-1){1'b0}}, (w_ctrl == CTRL_SUB)};
        w_res   = '0;
        w_ovf   = 1'b0;
        case (w_ctrl)
            CTRL_AND: w_res = a & b;
            CTRL_OR:  w_res = a | b;
            CTRL_ADD, CTRL_SUB: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            CTRL_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  w_res = '0;
        endcase
    end

    // {acc, mq} shifts right each step; after WIDTH steps it holds the full product.
    assign w_addend  = r_mq[0] ? r_mcand : '0;
    assign w_psum    = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_nxt = w_psum[WIDTH:1];
    assign w_mq_nxt  = {w_psum[0], r_mq[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mq        <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_aluctrl   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_ctrl == CTRL_MUL) begin
                            r_mcand <= a;
                            r_mq    <= b;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_zero      <= (w_res == '0);
                            r_ovf       <= w_ovf;
                            r_err       <= w_ill;
                            r_aluctrl   <= w_ctrl;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_result    <= w_mq_nxt;
                        r_result_hi <= w_acc_nxt;
                        r_zero      <= ({w_acc_nxt, w_mq_nxt} == '0);
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                        r_aluctrl   <= CTRL_MUL;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign err       = r_err;
    assign aluctrl   = r_aluctrl;

endmodule

// File: tb/tb_mc_alu_unit.sv
// Scoreboard bench for mc_alu_unit at WIDTH=32 and WIDTH=8 with hand-computed directed vectors.
module tb_mc_alu_unit;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        err;
        logic [2:0]  ctrl;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s_start;
    logic [1:0]  s_op;
    logic [5:0]  s_fn;
    logic [31:0] s_a, s_b;
    logic        d_busy, d_done, d_zero, d_ovf, d_err;
    logic [31:0] d_res, d_hi;
    logic [2:0]  d_ctrl;

    logic        t_start;
    logic [1:0]  t_op;
    logic [5:0]  t_fn;
    logic [7:0]  t_a, t_b;
    logic        e_busy, e_done, e_zero, e_ovf, e_err;
    logic [7:0]  e_res, e_hi;
    logic [2:0]  e_ctrl;

    mc_alu_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(s_start), .alu_op(s_op), .funct(s_fn),
        .a(s_a), .b(s_b), .busy(d_busy), .done(d_done), .result(d_res),
        .result_hi(d_hi), .zero(d_zero), .ovf(d_ovf), .err(d_err), .aluctrl(d_ctrl)
    );

    mc_alu_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(t_start), .alu_op(t_op), .funct(t_fn),
        .a(t_a), .b(t_b), .busy(e_busy), .done(e_done), .result(e_res),
        .result_hi(e_hi), .zero(e_zero), .ovf(e_ovf), .err(e_err), .aluctrl(e_ctrl)
    );

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_done === 1'b1) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL w32 unexpected done at cycle %0d", cyc);
            end else begin
                m32 = q32.pop_front();
                chk("w32 result",    64'(d_res),  64'(m32.res));
                chk("w32 result_hi", 64'(d_hi),   64'(m32.hi));
                chk("w32 flags",     64'({d_zero, d_ovf, d_err, d_ctrl}),
                                     64'({m32.zero, m32.ovf, m32.err, m32.ctrl}));
                chk("w32 latency",   64'(cyc - m32.acc + 1), 64'(m32.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (e_done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8 unexpected done at cycle %0d", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("w8 result",    64'(e_res), 64'(m8.res[7:0]));
                chk("w8 result_hi", 64'(e_hi),  64'(m8.hi[7:0]));
                chk("w8 flags",     64'({e_zero, e_ovf, e_err, e_ctrl}),
                                    64'({m8.zero, m8.ovf, m8.err, m8.ctrl}));
                chk("w8 latency",   64'(cyc - m8.acc + 1), 64'(m8.lat));
            end
        end
    end

    // Waits for the selected unit to be idle with nothing outstanding, then pulses start once.
    task automatic issue(input bit w8, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic ez, input logic eo, input logic ee,
                         input logic [2:0] ec, input int lat, input bit push);
        exp_t e;
        int   g = 0;
        @(negedge clk);
        while (g < 200 && (w8 ? (e_busy || e_done || q8.size() != 0)
                              : (d_busy || d_done || q32.size() != 0))) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++; errors++;
            $display("FAIL issue wait timeout w8=%0d", w8);
        end
        if (w8) begin
            t_op = op; t_fn = fn; t_a = a[7:0]; t_b = b[7:0]; t_start = 1'b1;
        end else begin
            s_op = op; s_fn = fn; s_a = a; s_b = b; s_start = 1'b1;
        end
        e.res = er; e.hi = eh; e.zero = ez; e.ovf = eo; e.err = ee; e.ctrl = ec;
        e.lat = lat; e.acc = cyc + 1;
        if (push) begin
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
        end
        @(negedge clk);
        if (w8) begin
            t_start = 1'b0; t_a = 8'h5A; t_b = 8'hA5;
        end else begin
            s_start = 1'b0; s_a = 32'hDEAD_BEEF; s_b = 32'h1357_9BDF;
        end
    endtask

    initial begin
        int   n;
        int   g;
        exp_t e;
        reset = 1'b1;
        s_start = 1'b0; s_op = 2'b00; s_fn = 6'd0; s_a = '0; s_b = '0;
        t_start = 1'b0; t_op = 2'b00; t_fn = 6'd0; t_a = '0; t_b = '0;
        repeat (3) @(negedge clk);
        chk("reset w32 outputs", 64'({d_busy, d_done, d_zero, d_ovf, d_err, d_ctrl}), 64'd0);
        chk("reset w32 result",  64'({d_res, d_hi}), 64'd0);
        chk("reset w8 outputs",  64'({e_busy, e_done, e_zero, e_ovf, e_err, e_ctrl, e_res, e_hi}), 64'd0);
        reset = 1'b0;

        // bit, op, funct, a, b, result, hi, zero, ovf, err, ctrl, latency, push
        issue(0, 2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 3'b000, 1, 1);
        issue(0, 2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 3'b010, 1, 1);
        issue(0, 2'b01, 6'b000000, 32'd5,        32'd5,        32'h00000000, 0, 1, 0, 0, 3'b110, 1, 1);
        issue(0, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 3'b111, 1, 1);
        issue(0, 2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0, 0, 3'b111, 1, 1);
        issue(0, 2'b10, 6'b100000, 32'd1,        32'd2,        32'h00000003, 0, 0, 0, 0, 3'b010, 1, 1);
        issue(0, 2'b10, 6'b100010, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 0, 1, 0, 3'b110, 1, 1);

        // Multiply with start pulses while busy; only the first request may complete.
        issue(0, 2'b10, 6'b011000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 0, 0, 0, 3'b011, 33, 1);
        n = 0; g = 0;
        while (d_done !== 1'b1 && g < 100) begin
            if (d_busy === 1'b1) n++;
            s_op = 2'b00;
            s_start = (g == 5 || g == 10 || g == 20) ? 1'b1 : 1'b0;
            g++;
            @(negedge clk);
        end
        s_start = 1'b0;
        chk("w32 mult busy cycles", 64'(n), 64'd32);

        issue(0, 2'b10, 6'b011000, 32'd0, 32'd5, 32'd0, 32'd0, 1, 0, 0, 3'b011, 33, 1);
        issue(0, 2'b10, 6'b111111, 32'd9, 32'd9, 32'd0, 32'd0, 1, 0, 1, 3'b100, 1, 1);
        issue(0, 2'b11, 6'b100000, 32'd9, 32'd9, 32'd0, 32'd0, 1, 0, 1, 3'b100, 1, 1);
        issue(0, 2'b10, 6'b100101, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 3'b001, 1, 1);

        // Start held for four edges: accepted only from IDLE, so exactly two completions.
        issue(1, 2'b10, 6'b100100, 32'hF0, 32'h3C, 32'h30, 0, 0, 0, 0, 3'b000, 1, 1);
        @(negedge clk);
        g = 0;
        while (g < 200 && (d_busy || d_done || q32.size() != 0 || e_busy || e_done || q8.size() != 0)) begin
            @(negedge clk);
            g++;
        end
        s_op = 2'b00; s_fn = 6'd0; s_a = 32'd1; s_b = 32'd1; s_start = 1'b1;
        e.res = 32'd2; e.hi = 0; e.zero = 0; e.ovf = 0; e.err = 0; e.ctrl = 3'b010; e.lat = 1;
        e.acc = cyc + 1; q32.push_back(e);
        e.acc = cyc + 3; q32.push_back(e);
        repeat (4) @(negedge clk);
        s_start = 1'b0;

        // Reset during a multiply: outputs from the previous op must clear.
        issue(0, 2'b10, 6'b100101, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0, 3'b001, 1, 1);
        issue(0, 2'b10, 6'b011000, 32'h00001234, 32'h00005678, 0, 0, 0, 0, 0, 3'b011, 33, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midmul reset flags",  64'({d_busy, d_done, d_zero, d_ovf, d_err, d_ctrl}), 64'd0);
        chk("midmul reset result", 64'({d_res, d_hi}), 64'd0);
        reset = 1'b0;
        issue(0, 2'b00, 6'b000000, 32'd3, 32'd4, 32'd7, 0, 0, 0, 0, 3'b010, 1, 1);

        issue(1, 2'b10, 6'b011000, 32'hFF, 32'hFF, 32'h01, 32'hFE, 0, 0, 0, 3'b011, 9, 1);
        issue(1, 2'b10, 6'b011000, 32'h0D, 32'h0B, 32'h8F, 32'h00, 0, 0, 0, 3'b011, 9, 1);
        issue(1, 2'b00, 6'b000000, 32'h7F, 32'h01, 32'h80, 32'h00, 0, 1, 0, 3'b010, 1, 1);

        g = 0;
        while ((q32.size() != 0 || q8.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain timeout pending32=%0d pending8=%0d", q32.size(), q8.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
